// File: rtl/seq_step_fsm.sv
// Parametrised step sequencer: walks a position through NUM_STEPS steps, up or down,
// with pause/restart, optional one-shot DONE hold and a saturating sequence counter.
module seq_step_fsm #(
  parameter int NUM_STEPS = 3,
  parameter int CNT_W     = 8,
  parameter bit ONESHOT   = 1'b0,
  localparam int STEP_W   = (NUM_STEPS > 2) ? $clog2(NUM_STEPS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pause,
  input  logic              restart,
  input  logic              dir,
  input  logic              count_clr,
  output logic [STEP_W-1:0] step,
  output logic              odd,
  output logic              even,
  output logic              terminal,
  output logic              done,
  output logic [CNT_W-1:0]  seq_count
);

  generate
    if (NUM_STEPS < 2) begin : g_bad_num_steps
      $error("seq_step_fsm: NUM_STEPS must be at least 2");
    end
  endgenerate

  localparam logic [STEP_W-1:0] FIRST = '0;
  localparam logic [STEP_W-1:0] LAST  = STEP_W'(NUM_STEPS - 1);

  localparam logic [0:0] ST_ACTIVE = 1'b0;
  localparam logic [0:0] ST_DONE   = 1'b1;

  logic [0:0]        state_q, state_nxt;
  logic [STEP_W-1:0] pos, pos_nxt;
  logic              dir_q, dir_nxt;
  logic [CNT_W-1:0]  cnt_q;

  logic [STEP_W-1:0] start_pos;
  logic [STEP_W-1:0] term_pos;
  logic              advance;
  logic              at_term;
  logic              out_range;

  assign start_pos = dir   ? LAST  : FIRST;
  assign term_pos  = dir_q ? FIRST : LAST;
  assign advance   = restart | ~pause;
  assign at_term   = (pos == term_pos);
  assign out_range = (pos > LAST);

  // While reset is held the registers sit at the start step with no latched
  // direction, so terminal simply follows whether the block would move on.
  assign terminal = !rst_n ? advance
                           : ((state_q == ST_ACTIVE) && at_term && advance);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state_q;
    pos_nxt   = pos;
    dir_nxt   = dir_q;
    case (state_q)
      ST_DONE: begin
        if (restart) begin
          state_nxt = ST_ACTIVE;
          pos_nxt   = start_pos;
          dir_nxt   = dir;
        end
      end
      default: begin
        if (restart || out_range) begin
          pos_nxt = start_pos;
          dir_nxt = dir;
        end else if (!pause) begin
          if (at_term) begin
            if (ONESHOT) begin
              state_nxt = ST_DONE;
              pos_nxt   = FIRST;
            end else begin
              pos_nxt = start_pos;
              dir_nxt = dir;
            end
          end else begin
            pos_nxt = dir_q ? (pos - 1'b1) : (pos + 1'b1);
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACTIVE;
      pos     <= FIRST;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      pos     <= pos_nxt;
      dir_q   <= dir_nxt;
    end
  end

  // Clear wins over counting; the counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (count_clr) begin
      cnt_q <= '0;
    end else if (terminal && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign step      = (state_q == ST_DONE) ? FIRST : pos;
  assign odd       = (state_q == ST_ACTIVE) && !pos[0];
  assign even      = (state_q == ST_ACTIVE) &&  pos[0];
  assign done      = ONESHOT && (state_q == ST_DONE);
  assign seq_count = cnt_q;

endmodule

// File: tb/tb_seq_step_fsm.sv
// Bench for seq_step_fsm: five configurations share one stimulus stream; each is
// compared every cycle against an abstract step/counter model, plus directed spot checks.
module tb_seq_step_fsm;

  typedef struct {
    int pos;
    bit dq;
    bit dn;
    int cnt;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause = 1'b0, restart = 1'b0, dir = 1'b0, count_clr = 1'b0;

  logic [1:0] a_step; logic a_odd, a_even, a_term, a_done; logic [7:0] a_cnt;
  logic [2:0] b_step; logic b_odd, b_even, b_term, b_done; logic [7:0] b_cnt;
  logic [1:0] c_step; logic c_odd, c_even, c_term, c_done; logic [7:0] c_cnt;
  logic [1:0] d_step; logic d_odd, d_even, d_term, d_done; logic [7:0] d_cnt;
  logic [1:0] e_step; logic e_odd, e_even, e_term, e_done; logic [1:0] e_cnt;

  int n_total = 0, n_pass = 0, n_fail = 0;
  mdl_t ma, mb, mc, md, me;

  always #5 clk = ~clk;

  seq_step_fsm #(.NUM_STEPS(3), .CNT_W(8), .ONESHOT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .pause(pause), .restart(restart), .dir(dir), .count_clr(count_clr),
    .step(a_step), .odd(a_odd), .even(a_even), .terminal(a_term), .done(a_done), .seq_count(a_cnt));
  seq_step_fsm #(.NUM_STEPS(5), .CNT_W(8), .ONESHOT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .pause(pause), .restart(restart), .dir(dir), .count_clr(count_clr),
    .step(b_step), .odd(b_odd), .even(b_even), .terminal(b_term), .done(b_done), .seq_count(b_cnt));
  seq_step_fsm #(.NUM_STEPS(4), .CNT_W(8), .ONESHOT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .pause(pause), .restart(restart), .dir(dir), .count_clr(count_clr),
    .step(c_step), .odd(c_odd), .even(c_even), .terminal(c_term), .done(c_done), .seq_count(c_cnt));
  seq_step_fsm #(.NUM_STEPS(3), .CNT_W(8), .ONESHOT(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n), .pause(pause), .restart(restart), .dir(dir), .count_clr(count_clr),
    .step(d_step), .odd(d_odd), .even(d_even), .terminal(d_term), .done(d_done), .seq_count(d_cnt));
  seq_step_fsm #(.NUM_STEPS(3), .CNT_W(2), .ONESHOT(1'b0)) dut_e (
    .clk(clk), .rst_n(rst_n), .pause(pause), .restart(restart), .dir(dir), .count_clr(count_clr),
    .step(e_step), .odd(e_odd), .even(e_even), .terminal(e_term), .done(e_done), .seq_count(e_cnt));

  // ---------------- reference model ----------------
  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.pos = 0; m.dq = 1'b0; m.dn = 1'b0; m.cnt = 0;
    return m;
  endfunction

  function automatic int first_of(bit d, int n);
    return d ? n - 1 : 0;
  endfunction

  function automatic bit term_now(mdl_t m, int n, bit p, bit r);
    return !m.dn && (m.pos == first_of(!m.dq, n)) && (r || !p);
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int n, bit os, int cw, bit p, bit r, bit d, bit c);
    mdl_t x = m;
    if (c) x.cnt = 0;
    else if (term_now(m, n, p, r) && m.cnt < (1 << cw) - 1) x.cnt = m.cnt + 1;
    if (r) begin
      x.dn = 1'b0; x.pos = first_of(d, n); x.dq = d;
    end else if (m.dn || p) begin
      // hold
    end else if (m.pos == first_of(!m.dq, n)) begin
      if (os) begin x.dn = 1'b1; x.pos = 0; end
      else begin x.pos = first_of(d, n); x.dq = d; end
    end else begin
      x.pos = m.dq ? m.pos - 1 : m.pos + 1;
    end
    return x;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_set(input string nm, input mdl_t m, input int n, input logic [31:0] st,
                         input logic o, input logic e, input logic t, input logic dn,
                         input logic [31:0] cnt);
    bit exp_t;
    exp_t = !rst_n ? (restart || !pause) : term_now(m, n, pause, restart);
    chk({nm, "_step"}, st, m.dn ? 0 : m.pos);
    chk({nm, "_odd"}, 32'(o), 32'(!m.dn && (m.pos % 2 == 0)));
    chk({nm, "_even"}, 32'(e), 32'(!m.dn && (m.pos % 2 == 1)));
    chk({nm, "_terminal"}, 32'(t), 32'(exp_t));
    chk({nm, "_done"}, 32'(dn), 32'(m.dn));
    chk({nm, "_count"}, cnt, m.cnt);
  endtask

  task automatic check_all();
    chk_set("a", ma, 3, 32'(a_step), a_odd, a_even, a_term, a_done, 32'(a_cnt));
    chk_set("b", mb, 5, 32'(b_step), b_odd, b_even, b_term, b_done, 32'(b_cnt));
    chk_set("c", mc, 4, 32'(c_step), c_odd, c_even, c_term, c_done, 32'(c_cnt));
    chk_set("d", md, 3, 32'(d_step), d_odd, d_even, d_term, d_done, 32'(d_cnt));
    chk_set("e", me, 3, 32'(e_step), e_odd, e_even, e_term, e_done, 32'(e_cnt));
  endtask

  // One clock cycle: apply inputs at the falling edge, check before the rising edge.
  task automatic cyc(input bit p, input bit r, input bit d, input bit c);
    mdl_t na, nb, nc, nd, ne;
    pause = p; restart = r; dir = d; count_clr = c;
    #1;
    check_all();
    na = mdl_next(ma, 3, 1'b0, 8, p, r, d, c);
    nb = mdl_next(mb, 5, 1'b0, 8, p, r, d, c);
    nc = mdl_next(mc, 4, 1'b0, 8, p, r, d, c);
    nd = mdl_next(md, 3, 1'b1, 8, p, r, d, c);
    ne = mdl_next(me, 3, 1'b0, 2, p, r, d, c);
    @(posedge clk);
    if (rst_n) begin
      ma = na; mb = nb; mc = nc; md = nd; me = ne;
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_c [9] = '{0, 1, 2, 3, 3, 2, 1, 0, 3};
    bit dir_pat [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int cnt_before;
    ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset(); md = mdl_reset(); me = mdl_reset();

    // Reset held: terminal follows restart | !pause
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);

    // Release with dir=1; first pass counts up, direction only takes effect at wraps
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pause = 1'b0; restart = 1'b0; dir = dir_pat[i]; #1;
      chk("a_trace", 32'(a_step), i % 3);
      chk("c_trace", 32'(c_step), exp_c[i]);
      cyc(1'b0, 1'b0, dir_pat[i], 1'b0);
    end
    chk("a_count_after9", 32'(a_cnt), 3);
    chk("d_done_hold", 32'(d_done), 1);

    // Pause at step 2 of the 5-step sequencer
    for (int i = 0; i < 10 && mb.pos != 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("b_pause_hold", 32'(b_step), 2);
    end
    for (int i = 0; i < 10 && mb.pos != 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    pause = 1'b1; restart = 1'b0; #1;
    chk("b_term_paused", 32'(b_term), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cnt_before = mb.cnt;
    pause = 1'b1; restart = 1'b1; #1;
    chk("b_term_restart", 32'(b_term), 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("b_after_restart", 32'(b_step), 0);
    chk("b_count_restart", 32'(b_cnt), cnt_before + 1);
    chk("d_restarted", 32'(d_done), 0);

    // One-shot: run into DONE, pause toggling holds it, restart leaves it
    for (int i = 0; i < 10 && !md.dn; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(i[0], 1'b0, 1'b1, 1'b0);
    chk("d_done_after_pause", 32'(d_done), 1);
    chk("d_step_done", 32'(d_step), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("d_left_done", 32'(d_done), 0);

    // Saturation on the 2-bit counter, then clear coinciding with terminal
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("e_saturated", 32'(e_cnt), 3);
    for (int i = 0; i < 10 && !term_now(me, 3, 1'b0, 1'b0); i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("e_clear_wins", 32'(e_cnt), 0);

    // Asynchronous reset mid-sequence at step 2
    for (int i = 0; i < 10 && ma.pos != 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    pause = 1'b0; restart = 1'b0; dir = 1'b0; count_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("a_async_step", 32'(a_step), 0);
    chk("a_async_count", 32'(a_cnt), 0);
    ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset(); md = mdl_reset(); me = mdl_reset();
    @(negedge clk);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(3) == 0, $urandom_range(15) == 0,
          $urandom_range(1) == 1, $urandom_range(31) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_step_fsm.md
Name: seq_step_fsm

Overview:
- Parametrised step-sequencer FSM. Cycles a position through NUM_STEPS steps with pause/restart control.
- Generalises the fixed three-state sequencer:
  - configurable length
  - runtime up/down direction
  - optional one-shot mode with a DONE hold
  - saturating completed-sequence counter
- Sits in the control path, driving step-indexed datapath enables and parity flags.

Parameters:
- NUM_STEPS, 3, number of sequence steps; must be ≥2 (elaboration error otherwise).
- CNT_W, 8, width of the completed-sequence counter.
- ONESHOT, 0, 0 = wrap to the start step after the terminal step; 1 = enter DONE after the terminal step.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- pause  input  1  hold current step.
- restart  input  1  return to start step; overrides pause.
- dir  input  1  0 = up (start 0, terminal NUM_STEPS-1); 1 = down (start NUM_STEPS-1, terminal 0); sampled only at sequence start.
- count_clr  input  1  synchronous clear of seq_count.
- step  output  STEP_W  current 0-based position, where STEP_W = max(1, clog2(NUM_STEPS)); 0 while in DONE.
- odd  output  1  1-based step number is odd, i.e. step[0]==0; 0 in DONE.
- even  output  1  1-based step number is even, i.e. step[0]==1; 0 in DONE.
- terminal  output  1  combinational; at terminal step and leaving it this cycle (restart | !pause); 0 in DONE.
- done  output  1  one-shot sequence finished (ONESHOT=1 only; tied 0 otherwise).
- seq_count  output  CNT_W  completed/aborted-at-terminal sequence count, saturating.

Behaviour:
- Registered state:
  - pos
  - dir_q (latched direction)
  - done_q
  - seq_count
- Only these change on the rising clk edge.
- step, odd, even and done are decoded from registers; terminal is combinational from registers and inputs.

Reset (rst_n low, immediate, asynchronous):
- pos=0, dir_q=0, done_q=0, seq_count=0.
- Outputs: step=0, odd=1, even=0, done=0; terminal = restart|!pause.
- Reset mid-sequence discards all progress.

Start position: start(d) = 0 if d==0, NUM_STEPS-1 if d==1. term(d) = the other end.

Next state, ACTIVE (done_q=0), priority top-down:
- restart: pos←start(dir), dir_q←dir.
- pause: hold pos.
- pos==term(dir_q):
  - ONESHOT=0: pos←start(dir), dir_q←dir (wrap).
  - ONESHOT=1: done_q←1, pos←0.
- otherwise: pos←pos+1 (dir_q=0) or pos−1 (dir_q=1).

Next state, DONE (done_q=1):
- restart: done_q←0, pos←start(dir), dir_q←dir.
- pause and all other inputs are ignored; the block holds.

Direction:
- dir changes mid-sequence have no effect until the next restart or wrap.
- Latency from restart to step=start is 1 cycle.

seq_count:
- count_clr → 0; this has priority over increment.
- Otherwise +1 on any cycle with terminal=1, saturating at 2^CNT_W−1 (no wrap).

Out-of-range pos (non-power-of-2 NUM_STEPS): next pos←start(dir) and dir_q←dir, regardless of pause.

Per-cycle sequences:
- A non-paused, non-restarted sequence visits each step for exactly 1 cycle.
- Wrap-mode period is NUM_STEPS cycles.

Test Plan:
1. NUM_STEPS=3 defaults, pause=restart=dir=0 after reset:
   - step 0,1,2,0,…
   - odd 1,0,1; even 0,1,0
   - terminal high at step 2
   - seq_count 1,2,3 after 3, 6, 9 cycles.
2. NUM_STEPS=5: pause held 3 cycles at step 2 → step stays 2 and terminal=0; at step 4 with pause=1 → terminal=0; assert restart with pause=1 at step 4 → terminal=1, next step 0, seq_count+1.
3. NUM_STEPS=4, dir=1 set at reset release:
   - first sequence runs 0,1,2,3 (dir_q=0 until wrap); then 3,2,1,0
   - toggling dir mid-sequence has no effect until wrap.
4. ONESHOT=1, NUM_STEPS=3:
   - 0,1,2 → done=1, step=0, odd=even=0
   - pause toggling keeps DONE
   - restart → done=0, step=0 next cycle.
5. CNT_W=2: run 5 sequences → seq_count saturates at 3; count_clr with terminal=1 in the same cycle → 0.
6. Drop rst_n mid-sequence at step 2 (asynchronously, between edges) → step=0 and seq_count=0 immediately; sequence resumes from 0 after release.
